stream_fifo_sink: RTL and testbench



---
 rtl/stream_pkg.sv | 14 +
 rtl/stream_fifo_mem.sv | 26 ++
 rtl/stream_fifo_sink.sv | 108 ++++++++++
 tb/tb_stream_fifo_sink.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the stream buffer blocks.
package stream_pkg;

    localparam int STREAM_DATA_W = 32;
    localparam int STREAM_CNT_W  = 32;

    typedef logic [STREAM_DATA_W-1:0] stream_data_t;

    // Width needed to represent an occupancy in the range 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module stream_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_sink.sv
// First-word-fall-through valid/ready buffer with occupancy output.
// Define STREAM_FIFO_SINK_STATS_EN to add push/pop/stall counters.
module stream_fifo_sink
    import stream_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = STREAM_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [level_width(DEPTH)-1:0] level
`ifdef STREAM_FIFO_SINK_STATS_EN
    ,
    output logic [STREAM_CNT_W-1:0]       xfer_in_cnt,
    output logic [STREAM_CNT_W-1:0]       xfer_out_cnt,
    output logic [STREAM_CNT_W-1:0]       stall_cnt
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int LVL_W = level_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  fill;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // The extra pointer MSB tells a full buffer apart from an empty one.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign fill  = wr_ptr - rd_ptr;
    assign level = LVL_W'(fill);

    assign out_data = out_valid ? head : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // A word pushed during a flush is never written, so it cannot resurface.
    stream_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

`ifdef STREAM_FIFO_SINK_STATS_EN
    localparam logic [STREAM_CNT_W-1:0] CNT_ONE = 1;

    // Counters survive flush; only the hardware reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_in_cnt  <= '0;
            xfer_out_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (push) begin
                xfer_in_cnt <= xfer_in_cnt + CNT_ONE;
            end
            if (pop) begin
                xfer_out_cnt <= xfer_out_cnt + CNT_ONE;
            end
            if (in_valid && !in_ready) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo_sink.sv
// Directed, table-driven bench for stream_fifo_sink (DEPTH=4, DATA_W=32).
// Counter checks are included when STREAM_FIFO_SINK_STATS_EN is defined.
module tb_stream_fifo_sink;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
`ifdef STREAM_FIFO_SINK_STATS_EN
    logic [31:0] xfer_in_cnt;
    logic [31:0] xfer_out_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        flush;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic [2:0]  exp_level;
    } vec_t;

    vec_t vecs [10];

    stream_fifo_sink #(
        .DEPTH  (4),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level)
`ifdef STREAM_FIFO_SINK_STATS_EN
        ,
        .xfer_in_cnt  (xfer_in_cnt),
        .xfer_out_cnt (xfer_out_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic v, input logic [31:0] d, input logic r,
                                   input logic f, input logic eir, input logic eov,
                                   input logic [31:0] eod, input logic [2:0] elvl);
        vec_t t;
        t.in_valid      = v;
        t.in_data       = d;
        t.out_ready     = r;
        t.flush         = f;
        t.exp_in_ready  = eir;
        t.exp_out_valid = eov;
        t.exp_out_data  = eod;
        t.exp_level     = elvl;
        return t;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Outputs are sampled on the falling edge, before the next commit.
    task automatic checkOutput(input string name, input logic eir, input logic eov,
                               input logic [31:0] eod, input logic [2:0] elvl);
        @(negedge clk);
        checkVal({name, ".in_ready"},  {31'd0, in_ready},  {31'd0, eir});
        checkVal({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
        checkVal({name, ".out_data"},  out_data,           eod);
        checkVal({name, ".level"},     {29'd0, level},     {29'd0, elvl});
    endtask

    task automatic step(input string name, input logic v, input logic [31:0] d, input logic r,
                        input logic f, input logic eir, input logic eov,
                        input logic [31:0] eod, input logic [2:0] elvl);
        applyStimulus(v, d, r, f);
        checkOutput(name, eir, eov, eod, elvl);
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Fill to full, hold a fifth word, then drain in order.
        vecs[0] = mkVec(1, 32'hA0, 0, 0, 1, 0, 32'h00, 3'd0);
        vecs[1] = mkVec(1, 32'hA1, 0, 0, 1, 1, 32'hA0, 3'd1);
        vecs[2] = mkVec(1, 32'hA2, 0, 0, 1, 1, 32'hA0, 3'd2);
        vecs[3] = mkVec(1, 32'hA3, 0, 0, 1, 1, 32'hA0, 3'd3);
        vecs[4] = mkVec(1, 32'hA4, 0, 0, 0, 1, 32'hA0, 3'd4);
        vecs[5] = mkVec(1, 32'hA4, 1, 0, 0, 1, 32'hA0, 3'd4);
        vecs[6] = mkVec(0, 32'h00, 1, 0, 1, 1, 32'hA1, 3'd3);
        vecs[7] = mkVec(0, 32'h00, 1, 0, 1, 1, 32'hA2, 3'd2);
        vecs[8] = mkVec(0, 32'h00, 1, 0, 1, 1, 32'hA3, 3'd1);
        vecs[9] = mkVec(0, 32'h00, 0, 0, 1, 0, 32'h00, 3'd0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset.in_ready",  {31'd0, in_ready},  32'd1);
        checkVal("reset.out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("reset.out_data",  out_data,           32'd0);
        checkVal("reset.level",     {29'd0, level},     32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready,
                 vecs[i].flush, vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                 vecs[i].exp_out_data, vecs[i].exp_level);
        end

        // Prime to level 2, then push and pop together; pointers wrap past 7.
        step("prime0", 1, 32'hB0, 0, 0, 1, 0, 32'h00, 3'd0);
        step("prime1", 1, 32'hB1, 0, 0, 1, 1, 32'hB0, 3'd1);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("pp%0d", i), 1, 32'hB2 + 32'(i), 1, 0, 1, 1, 32'hB0 + 32'(i), 3'd2);
        end
        step("ppdrain0", 0, 32'h00, 1, 0, 1, 1, 32'hBA, 3'd2);
        step("ppdrain1", 0, 32'h00, 1, 0, 1, 1, 32'hBB, 3'd1);
        step("ppempty",  0, 32'h00, 0, 0, 1, 0, 32'h00, 3'd0);

        // Flush at level 3 with a concurrent push; C3 must never appear.
        step("fl0",    1, 32'hC0, 0, 0, 1, 0, 32'h00, 3'd0);
        step("fl1",    1, 32'hC1, 0, 0, 1, 1, 32'hC0, 3'd1);
        step("fl2",    1, 32'hC2, 0, 0, 1, 1, 32'hC0, 3'd2);
        step("flush",  1, 32'hC3, 0, 1, 1, 1, 32'hC0, 3'd3);
        step("flpost", 1, 32'hD0, 0, 0, 1, 0, 32'h00, 3'd0);
        step("flnext", 0, 32'h00, 1, 0, 1, 1, 32'hD0, 3'd1);
        step("flidle", 0, 32'h00, 0, 0, 1, 0, 32'h00, 3'd0);

        // Asynchronous reset with words buffered.
        step("rst0", 1, 32'hE0, 0, 0, 1, 0, 32'h00, 3'd0);
        step("rst1", 0, 32'h00, 0, 0, 1, 1, 32'hE0, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("midrst.in_ready",  {31'd0, in_ready},  32'd1);
        checkVal("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        checkVal("midrst.out_data",  out_data,           32'd0);
        checkVal("midrst.level",     {29'd0, level},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef STREAM_FIFO_SINK_STATS_EN
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'hF0 + 32'(i), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'hF4, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h00, 1, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 32'hF8 + 32'(i), 0, 0);
        applyStimulus(0, 32'h00, 0, 0);
        @(negedge clk);
        checkVal("stats.xfer_in_cnt",  xfer_in_cnt,    32'd6);
        checkVal("stats.xfer_out_cnt", xfer_out_cnt,   32'd4);
        checkVal("stats.stall_cnt",    stall_cnt,      32'd3);
        checkVal("stats.level",        {29'd0, level}, 32'd2);
        rst_n = 1'b0;
        #1;
        checkVal("statsrst.xfer_in_cnt",  xfer_in_cnt,  32'd0);
        checkVal("statsrst.xfer_out_cnt", xfer_out_cnt, 32'd0);
        checkVal("statsrst.stall_cnt",    stall_cnt,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
